// File: rtl/gba_lcd_capture_if.sv
// gba_lcd_capture_if: LCD input pins and framebuffer write port of the capture block
interface gba_lcd_capture_if;
   logic        i_DCLK;
   logic        i_LP;
   logic        i_SPS;
   logic [4:0]  i_R;
   logic [4:0]  i_G;
   logic [4:0]  i_B;
   logic        o_wrclk;
   logic        o_wre;
   logic [15:0] o_wraddr;
   logic [14:0] o_data;
   logic        o_frame_done;
   logic [7:0]  o_LED;
   modport master (
      input  i_DCLK, i_LP, i_SPS, i_R, i_G, i_B,
      output o_wrclk, o_wre, o_wraddr, o_data, o_frame_done, o_LED
   );
   modport slave (
      output i_DCLK, i_LP, i_SPS, i_R, i_G, i_B,
      input  o_wrclk, o_wre, o_wraddr, o_data, o_frame_done, o_LED
   );
endinterface

// File: rtl/gba_lcd_capture.sv
// gba_lcd_capture: samples the GBA LCD bus into a linear framebuffer; define GBA_CAP_BGR_EN for {B,G,R} pixel order
module gba_lcd_capture #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 160
) (
   input logic i_clk,
   input logic i_rst_n,
   gba_lcd_capture_if.master bus
);
   localparam int HW = $clog2(WIDTH + 1);
   localparam int VW = $clog2(HEIGHT + 1);
   typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
   state_t state;
   logic [1:0] dclk_s, lp_s, sps_s;
   logic dclk_d, lp_d, sps_d;
   logic [1:0][4:0] r_s, g_s, b_s;
   logic [HW-1:0] h, hh, h_wr;
   logic [VW-1:0] v, vv;
   logic dclk_e, lp_e, sps_e, run, wr, adv;
   logic [15:0] addr;
   logic [14:0] pix;
   assign bus.o_wrclk = i_clk;
   // An SPS edge restarts position before anything else, so a coincident pixel lands at address 0
   always_comb begin
      dclk_e = dclk_s[1] & ~dclk_d;
      lp_e   = lp_s[1] & ~lp_d;
      sps_e  = sps_s[1] & ~sps_d;
      run    = (state == ACTIVE) | sps_e;
      hh     = sps_e ? '0 : h;
      vv     = sps_e ? '0 : v;
      wr     = run & dclk_e & (hh < HW'(WIDTH)) & (vv < VW'(HEIGHT));
      h_wr   = wr ? hh + 1'b1 : hh;
      adv    = run & lp_e & ~sps_e & (h_wr != '0);
      addr   = 16'(vv) * 16'(WIDTH) + 16'(hh);
`ifdef GBA_CAP_BGR_EN
      pix    = {b_s[1], g_s[1], r_s[1]};
`else
      pix    = {r_s[1], g_s[1], b_s[1]};
`endif
   end
   // Synchronisers, edge registers and the frame FSM with its registered write port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dclk_s <= '0;
         lp_s <= '0;
         sps_s <= '0;
         dclk_d <= 1'b0;
         lp_d <= 1'b0;
         sps_d <= 1'b0;
         r_s <= '0;
         g_s <= '0;
         b_s <= '0;
         state <= WAIT_FRAME;
         h <= '0;
         v <= '0;
         bus.o_wre <= 1'b0;
         bus.o_wraddr <= '0;
         bus.o_data <= '0;
         bus.o_frame_done <= 1'b0;
         bus.o_LED <= '0;
      end else begin
         dclk_s <= {dclk_s[0], bus.i_DCLK};
         lp_s <= {lp_s[0], bus.i_LP};
         sps_s <= {sps_s[0], bus.i_SPS};
         dclk_d <= dclk_s[1];
         lp_d <= lp_s[1];
         sps_d <= sps_s[1];
         r_s <= {r_s[0], bus.i_R};
         g_s <= {g_s[0], bus.i_G};
         b_s <= {b_s[0], bus.i_B};
         bus.o_wre <= wr;
         bus.o_frame_done <= 1'b0;
         if (wr) begin
            bus.o_wraddr <= addr;
            bus.o_data <= pix;
         end
         if (run) begin
            state <= ACTIVE;
            h <= h_wr;
            v <= vv;
            if (adv) begin
               h <= '0;
               if (vv == VW'(HEIGHT - 1)) begin
                  v <= '0;
                  state <= WAIT_FRAME;
                  bus.o_frame_done <= 1'b1;
                  bus.o_LED <= bus.o_LED + 1'b1;
               end else begin
                  v <= vv + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_gba_lcd_capture.sv
// tb_gba_lcd_capture: scoreboard bench for the LCD capture block
module tb_gba_lcd_capture;
   typedef struct packed {logic [15:0] a; logic [14:0] d;} exp_t;
   typedef struct {logic [4:0] r, g, b; logic [14:0] rgb, bgr;} vec_t;
`ifdef GBA_CAP_BGR_EN
   localparam logic [14:0] RED = 15'h001F;
`else
   localparam logic [14:0] RED = 15'h7C00;
`endif
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int fd_cnt = 0;
   logic [15:0] last_addr = '0;
   exp_t q[$];
   vec_t tbl[5];
   gba_lcd_capture_if bus();
   gba_lcd_capture dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));
   always #5 i_clk = ~i_clk;

   task automatic chk(string n, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic ev(bit d, bit l, bit s, logic [4:0] r, logic [4:0] g, logic [4:0] b,
                     bit exp, int a, logic [14:0] dat);
      if (exp) q.push_back({16'(a), dat});
      bus.i_R = r;
      bus.i_G = g;
      bus.i_B = b;
      bus.i_DCLK = d;
      bus.i_LP = l;
      bus.i_SPS = s;
      tick(2);
      bus.i_DCLK = 1'b0;
      bus.i_LP = 1'b0;
      bus.i_SPS = 1'b0;
      tick(2);
   endtask

   task automatic red(bit exp, int a);
      ev(1'b1, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0, exp, a, RED);
   endtask

   task automatic lp();
      ev(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 15'd0);
   endtask

   task automatic sps();
      ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 0, 15'd0);
   endtask

   task automatic drain(string n);
      tick(8);
      chk(n, q.size(), 0);
   endtask

   always @(negedge i_clk) begin
      exp_t e;
      if (bus.o_frame_done) fd_cnt++;
      if (bus.o_wre) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write: got write addr=%0d data=%h, expected no write", bus.o_wraddr, bus.o_data);
         end else begin
            e = q.pop_front();
            chk("wr_addr", int'(bus.o_wraddr), int'(e.a));
            chk("wr_data", int'(bus.o_data), int'(e.d));
         end
         last_addr = bus.o_wraddr;
      end
   end

   initial begin
      tbl[0] = '{5'd31, 5'd0,  5'd0,  15'h7C00, 15'h001F};
      tbl[1] = '{5'd0,  5'd31, 5'd0,  15'h03E0, 15'h03E0};
      tbl[2] = '{5'd0,  5'd0,  5'd31, 15'h001F, 15'h7C00};
      tbl[3] = '{5'd1,  5'd2,  5'd3,  15'h0443, 15'h0C41};
      tbl[4] = '{5'd21, 5'd10, 5'd5,  15'h5545, 15'h1555};
      bus.i_DCLK = 1'b0;
      bus.i_LP = 1'b0;
      bus.i_SPS = 1'b0;
      bus.i_R = '0;
      bus.i_G = '0;
      bus.i_B = '0;
      tick(4);
      chk("rst_wre", int'(bus.o_wre), 0);
      chk("rst_wraddr", int'(bus.o_wraddr), 0);
      chk("rst_data", int'(bus.o_data), 0);
      chk("rst_frame_done", int'(bus.o_frame_done), 0);
      chk("rst_led", int'(bus.o_LED), 0);
      i_rst_n = 1'b1;
      tick(2);
      for (int i = 0; i < 3; i++) red(1'b0, 0);
      drain("no_sps_no_write");
      sps();
      for (int i = 0; i < 250; i++) red(i < 240, i);
      lp();
      for (int i = 0; i < 5; i++)
`ifdef GBA_CAP_BGR_EN
         ev(1'b1, 1'b0, 1'b0, tbl[i].r, tbl[i].g, tbl[i].b, 1'b1, 240 + i, tbl[i].bgr);
`else
         ev(1'b1, 1'b0, 1'b0, tbl[i].r, tbl[i].g, tbl[i].b, 1'b1, 240 + i, tbl[i].rgb);
`endif
      lp();
      for (int v = 2; v < 159; v++) begin
         red(1'b1, v * 240);
         lp();
      end
      for (int h = 0; h < 240; h++) red(1'b1, 159 * 240 + h);
      lp();
      drain("frame_pending");
      chk("frame_done_cnt", fd_cnt, 1);
      chk("led_after_frame", int'(bus.o_LED), 1);
      chk("last_addr", int'(last_addr), 38399);
      red(1'b0, 0);
      lp();
      red(1'b0, 0);
      drain("wait_frame_ignore");
      sps();
      red(1'b1, 0);
      lp();
      red(1'b1, 240);
      lp();
      for (int h = 0; h < 5; h++) red(1'b1, 480 + h);
      ev(1'b1, 1'b1, 1'b0, 5'd31, 5'd0, 5'd0, 1'b1, 485, RED);
      red(1'b1, 720);
      lp();
      for (int v = 4; v < 80; v++) begin
         red(1'b1, v * 240);
         lp();
      end
      red(1'b1, 19200);
      drain("pre_reset");
      i_rst_n = 1'b0;
      tick(2);
      chk("mid_rst_wre", int'(bus.o_wre), 0);
      chk("mid_rst_led", int'(bus.o_LED), 0);
      i_rst_n = 1'b1;
      tick(2);
      for (int i = 0; i < 3; i++) red(1'b0, 0);
      lp();
      drain("post_reset_no_write");
      sps();
      red(1'b1, 0);
      red(1'b1, 1);
      ev(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 0, tbl[3].rgb ^ ((tbl[3].rgb ^ tbl[3].bgr) & {15{RED == 15'h001F}}));
      red(1'b1, 1);
      drain("sps_restart");
      chk("restart_no_frame_done", fd_cnt, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gba_lcd_capture.md
GBA_LCD_CAPTURE -- requirements
Module: gba_lcd_capture

Interface
REQ-001 SHALL have port i_clk, input, 1, system clock; all state is in this domain; the block shall be operated with i_clk >= 4x the i_DCLK frequency.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_DCLK, input, 1, LCD pixel clock, asynchronous to i_clk.
REQ-004 SHALL have port i_LP, input, 1, LCD line pulse, asynchronous.
REQ-005 SHALL have port i_SPS, input, 1, LCD frame start pulse, asynchronous.
REQ-006 SHALL have ports i_R, i_G, i_B, input, 5 each, pixel colour, stable around the i_DCLK rising edge.
REQ-007 SHALL have port o_wrclk, output, 1, framebuffer write clock, equal to i_clk.
REQ-008 SHALL have port o_wre, output, 1, framebuffer write enable, a one-cycle pulse per pixel.
REQ-009 SHALL have port o_wraddr, output, 16, framebuffer word address.
REQ-010 SHALL have port o_data, output, 15, pixel word.
REQ-011 SHALL have port o_frame_done, output, 1, one-cycle pulse when a complete frame has been written.
REQ-012 SHALL have port o_LED, output, 8, frame counter.
REQ-013 SHALL have parameter WIDTH, default 240, pixels per line.
REQ-014 SHALL have parameter HEIGHT, default 160, lines per frame.

Function
REQ-015 SHALL synchronise i_DCLK, i_LP and i_SPS through two flops each, and SHALL detect rising edges with one further register.
REQ-016 SHALL delay i_R, i_G and i_B through the same two flop stages, so colour is sampled aligned with the detected DCLK edge.
REQ-017 SHALL implement FSM states WAIT_FRAME and ACTIVE; WAIT_FRAME -> ACTIVE on an SPS edge, which also sets h=0 and v=0.
REQ-018 In WAIT_FRAME, SHALL ignore DCLK and LP edges and SHALL keep o_wre=0.
REQ-019 In ACTIVE, on a DCLK edge with h<WIDTH and v<HEIGHT, SHALL register o_wraddr=v*WIDTH+h and o_data={R,G,B}, pulse o_wre for one cycle, then set h=h+1.
REQ-020 SHALL discard DCLK edges once h>=WIDTH, with no write and h saturating at WIDTH.
REQ-021 On an LP edge in ACTIVE with h>0, SHALL set h=0 and v=v+1; an LP edge with h==0 SHALL be ignored.
REQ-022 When v reaches HEIGHT, SHALL pulse o_frame_done for one cycle, increment o_LED (wrapping 255->0), and return to WAIT_FRAME.
REQ-023 An SPS edge in ACTIVE SHALL restart the frame at h=0, v=0, with no o_frame_done pulse.
REQ-024 On simultaneous DCLK and LP edges, SHALL write the pixel at the current (v,h) first, then apply the line advance.
REQ-025 On simultaneous SPS and DCLK edges, SHALL apply the restart and write the pixel at address 0.
REQ-026 Latency from an i_DCLK rising edge at the pin to o_wre SHALL be 3 to 4 i_clk cycles.
REQ-027 The address product SHALL be computed in 16 bits; the maximum address is 38399.

Reset
REQ-028 While i_rst_n=0, SHALL force: state=WAIT_FRAME; h=v=0; o_wre=0; o_wraddr=0; o_data=0; o_frame_done=0; o_LED=0; all synchroniser and edge flops to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further writes; after release, writing resumes only after a new SPS edge.

Configuration
REQ-030 With macro GBA_CAP_BGR_EN defined, o_data SHALL be {B,G,R}.
REQ-031 Without GBA_CAP_BGR_EN, o_data SHALL be {R,G,B}; no other behaviour changes.

Verification
REQ-032 Reset, SPS, then 240 DCLK with R=31,G=0,B=0 -> 240 o_wre pulses, addresses 0..239, o_data=15'h7C00.
REQ-033 Full 160-line frame with an LP after each line -> last address 38399; one o_frame_done pulse; o_LED=1.
REQ-034 250 DCLK in one line -> exactly 240 writes, then LP -> next write at address 240.
REQ-035 DCLK and LP edges in the same cycle at h=5, v=2 -> write at address 485, next write at address 720.
REQ-036 Reset pulse at v=80, then DCLK edges without SPS -> no o_wre; after SPS, first write at address 0.
REQ-037 With GBA_CAP_BGR_EN defined, R=31,G=0,B=0 -> o_data=15'h001F.
